ins_fetch_mem: RTL and testbench

INS_FETCH_MEM -- requirements
Module: ins_fetch_mem

---
 rtl/ins_fetch_mem.sv | 130 +++++++++++++
 tb/tb_ins_fetch_mem.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_mem.sv
// rtl/ins_fetch_mem.sv - instruction memory with streamed program loader and 1-cycle fetch port
//
// A program is streamed in with ld_start followed by ld_valid/ld_data/ld_last
// words. Once the load completes, the block serves fetches by byte PC with a
// registered 1-cycle result.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ld_start             begin a program load (IDLE/RUN only)
//   ld_valid, ld_data    load word handshake; accepted when ld_ready=1
//   ld_last              marks the final load word
//   ld_ready             loader accepts a word this cycle
//   ld_done              one-cycle pulse when a load completes
//   fetch_req, stall, pc fetch request, pipeline stall, byte address
//   ins, ins_valid       fetched instruction and its freshness flag
//   fault                ins comes from a faulted fetch
module ins_fetch_mem #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 PC_W     = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] ins,
  output logic              ins_valid,
  output logic              fault
);

  localparam int DEPTH = 1 << ADDR_W;
  // wptr value of the DEPTH-th word; accepting it ends the load so wptr never wraps
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [PC_W-1:0]   pc_hi;
  logic              fetch_fault;
  logic              accept;

  assign idx    = pc[ADDR_W+1:2];
  // any bit above the word index makes the address out of range
  assign pc_hi  = pc >> (ADDR_W + 2);
  assign fetch_fault = (pc[1:0] != 2'b00) || (pc_hi != '0) || ({1'b0, idx} >= cnt);
  // ld_ready is only ever high in LOAD, so this is the full accept condition
  assign accept = ld_valid && ld_ready;

  // Memory has no reset: contents survive reset, cnt=0 keeps them unreachable
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr[ADDR_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      cnt       <= '0;
      ins       <= NOP_WORD;
      ins_valid <= 1'b0;
      fault     <= 1'b0;
      ld_ready  <= 1'b0;
      ld_done   <= 1'b0;
    end else begin
      ld_done <= 1'b0;

      case (state)
        IDLE, RUN: begin
          if (ld_start) begin
            state    <= LOAD;
            wptr     <= '0;
            cnt      <= '0;
            ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          // ld_start is deliberately ignored here: no restart mid-load
          if (accept) begin
            wptr <= wptr + 1'b1;
            cnt  <= cnt + 1'b1;
            if (ld_last || (wptr == LAST_PTR)) begin
              state    <= RUN;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
        end
      endcase

      // Fetch path. ld_start wins over a same-cycle fetch; stall freezes outputs.
      if ((state != RUN) || ld_start) begin
        ins_valid <= 1'b0;
        fault     <= 1'b0;
      end else if (!stall) begin
        if (fetch_req) begin
          ins       <= fetch_fault ? NOP_WORD : mem[idx];
          fault     <= fetch_fault;
          ins_valid <= 1'b1;
        end else begin
          ins_valid <= 1'b0;
          fault     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch_mem.sv
// tb/tb_ins_fetch_mem.sv - directed self-checking bench for ins_fetch_mem
module tb_ins_fetch_mem;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        fetch_req;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        ins_valid;
  logic        fault;

  int total;
  int bad;

  ins_fetch_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .fetch_req (fetch_req),
    .stall     (stall),
    .pc        (pc),
    .ins       (ins),
    .ins_valid (ins_valid),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    fetch_req = 1'b0; stall = 1'b0; pc = '0;
    #3;
    total++;
    if ({ins_valid, fault, ld_ready, ld_done} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {ins_valid, fault, ld_ready, ld_done});
    end
    total++;
    if (ins !== 32'h0) begin
      bad++; $display("FAIL reset_ins got=%h exp=00000000", ins);
    end
    #14 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_fetch();
    fetch_req = 1'b1; pc = 32'h0;
    tick();
    total++;
    if (ins_valid !== 1'b0) begin
      bad++; $display("FAIL idle_fetch_valid got=%b exp=0", ins_valid);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_load4();
    logic [31:0] words [4];
    logic        exp_done;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    total++;
    if (ld_ready !== 1'b0) begin
      bad++; $display("FAIL idle_ld_ready got=%b exp=0", ld_ready);
    end
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    total++;
    if (ld_ready !== 1'b1) begin
      bad++; $display("FAIL load4_ready got=%b exp=1", ld_ready);
    end
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      tick();
      exp_done = (i == 3);
      total++;
      if (ld_done !== exp_done) begin
        bad++; $display("FAIL load4_done_w%0d got=%b exp=%b", i, ld_done, exp_done);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    total++;
    if ({ld_done, ld_ready} !== 2'b00) begin
      bad++; $display("FAIL load4_done_pulse got=%b exp=00", {ld_done, ld_ready});
    end
    fetch_req = 1'b1; pc = 32'h8;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h33, 1'b1, 1'b0}) begin
      bad++; $display("FAIL fetch_8 got=%h/%b/%b exp=00000033/1/0", ins, ins_valid, fault);
    end
    pc = 32'h0;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h11, 1'b1, 1'b0}) begin
      bad++; $display("FAIL fetch_0 got=%h/%b/%b exp=00000011/1/0", ins, ins_valid, fault);
    end
    fetch_req = 1'b0;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h11, 1'b0, 1'b0}) begin
      bad++; $display("FAIL no_fetch got=%h/%b/%b exp=00000011/0/0", ins, ins_valid, fault);
    end
  endtask

  task automatic test_faults();
    logic [31:0] pcs [3];
    pcs[0] = 32'h10; pcs[1] = 32'h6; pcs[2] = 32'h80;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; pc = pcs[i];
      tick();
      total++;
      if ({ins, ins_valid, fault} !== {32'h0, 1'b1, 1'b1}) begin
        bad++; $display("FAIL fault_pc%h got=%h/%b/%b exp=00000000/1/1", pcs[i], ins, ins_valid, fault);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_stall();
    fetch_req = 1'b1; pc = 32'h4;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h22, 1'b1, 1'b0}) begin
      bad++; $display("FAIL stall_pre got=%h/%b/%b exp=00000022/1/0", ins, ins_valid, fault);
    end
    stall = 1'b1; pc = 32'hC;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({ins, ins_valid, fault} !== {32'h22, 1'b1, 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%b/%b exp=00000022/1/0", i, ins, ins_valid, fault);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h44, 1'b1, 1'b0}) begin
      bad++; $display("FAIL stall_release got=%h/%b/%b exp=00000044/1/0", ins, ins_valid, fault);
    end
  endtask

  task automatic test_ld_start_priority();
    ld_start = 1'b1; fetch_req = 1'b1; pc = 32'h0;
    tick();
    ld_start = 1'b0; fetch_req = 1'b0;
    total++;
    if ({ins_valid, ld_ready} !== 2'b01) begin
      bad++; $display("FAIL ldstart_prio got=%b exp=01", {ins_valid, ld_ready});
    end
  endtask

  task automatic test_full_load();
    logic exp_done;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = 32'h1000 + i; ld_last = 1'b0;
      ld_start = (i == 5);
      tick();
      exp_done = (i == 31);
      total++;
      if (ld_done !== exp_done) begin
        bad++; $display("FAIL full_done_w%0d got=%b exp=%b", i, ld_done, exp_done);
      end
    end
    ld_start = 1'b0;
    total++;
    if (ld_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready_after got=%b exp=0", ld_ready);
    end
    ld_data = 32'hDEAD;
    tick();
    ld_valid = 1'b0;
    total++;
    if ({ld_done, ld_ready} !== 2'b00) begin
      bad++; $display("FAIL full_33rd got=%b exp=00", {ld_done, ld_ready});
    end
    fetch_req = 1'b1; pc = 32'h7C;
    tick();
    total++;
    if ({ins, fault} !== {32'h101F, 1'b0}) begin
      bad++; $display("FAIL full_fetch_7c got=%h/%b exp=0000101f/0", ins, fault);
    end
    pc = 32'h14;
    tick();
    total++;
    if ({ins, fault} !== {32'h1005, 1'b0}) begin
      bad++; $display("FAIL full_fetch_14 got=%h/%b exp=00001005/0", ins, fault);
    end
    pc = 32'h0;
    tick();
    total++;
    if ({ins, fault} !== {32'h1000, 1'b0}) begin
      bad++; $display("FAIL full_fetch_0 got=%h/%b exp=00001000/0", ins, fault);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_midload();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + i; ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    total++;
    if ({ld_ready, ld_done, ins} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL midload_reset got=%b/%b/%h exp=0/0/00000000", ld_ready, ld_done, ins);
    end
    #2 rst_n = 1'b1;
    fetch_req = 1'b1; pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({ld_done, ins_valid, ld_ready} !== 3'b000) begin
        bad++; $display("FAIL midload_idle%0d got=%b exp=000", i, {ld_done, ins_valid, ld_ready});
      end
    end
    fetch_req = 1'b0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h55; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    total++;
    if (ld_done !== 1'b1) begin
      bad++; $display("FAIL reload_done got=%b exp=1", ld_done);
    end
    fetch_req = 1'b1; pc = 32'h4;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL reload_pc4 got=%h/%b/%b exp=00000000/1/1", ins, ins_valid, fault);
    end
    pc = 32'h0;
    tick();
    total++;
    if ({ins, ins_valid, fault} !== {32'h55, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reload_pc0 got=%h/%b/%b exp=00000055/1/0", ins, ins_valid, fault);
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_idle_fetch();
    test_load4();
    test_faults();
    test_stall();
    test_ld_start_priority();
    test_full_load();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
